// File: rtl/pbs_pkg.sv
// pbs_pkg: state codes, move opcodes and catch defaults shared by the battle menu blocks.
package pbs_pkg;
   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LOAD    = 4'd1,
      S_WAIT_GO = 4'd2,
      S_P_ACT   = 4'd3,
      S_P_CHK   = 4'd4,
      S_AI_ACT  = 4'd5,
      S_AI_CHK  = 4'd6,
      S_WIN     = 4'd7,
      S_LOSE    = 4'd8
   } state_t;
   localparam logic [1:0] MOVE_ATK   = 2'b00;
   localparam logic [1:0] MOVE_HEAL  = 2'b01;
   localparam logic [1:0] MOVE_CATCH = 2'b10;
   localparam logic [1:0] MOVE_RUN   = 2'b11;
   localparam int CATCH_HP_DEF   = 3;
   localparam int CATCH_ODDS_DEF = 8;
endpackage

// File: rtl/battle_turn_ctrl_go_edge.sv
// go_edge: registers the go level and emits a registered one-cycle pulse on its rising edge.
module go_edge (
   input  logic clk,
   input  logic reset_n,
   input  logic go,
   output logic rise
);
   logic go_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         go_q <= 1'b0;
         rise <= 1'b0;
      end else begin
         go_q <= go;
         rise <= go & ~go_q;
      end
endmodule

// File: rtl/battle_turn_ctrl.sv
// battle_turn_ctrl: player/AI turn sequencer driving the battle datapath strobes.
module battle_turn_ctrl
   import pbs_pkg::*;
#(
   parameter int HP_W       = 4,
   parameter int CATCH_HP   = CATCH_HP_DEF,
   parameter int CATCH_ODDS = CATCH_ODDS_DEF,
   parameter int TURN_W     = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              go,
   input  logic [1:0]        move_op,
   input  logic [HP_W-1:0]   accu,
   input  logic [HP_W-1:0]   ai_accu,
   input  logic [HP_W-1:0]   rng,
   input  logic [HP_W-1:0]   ai_hp,
   input  logic              p_dead,
   input  logic              ai_dead,
   output logic              load_ai_hp,
   output logic              apply_ai_damage,
   output logic              apply_p_damage,
   output logic              p_heal,
   output logic              active_trainer,
   output logic              victory,
   output logic              loss,
   output logic              caught,
   output logic              missed,
   output logic [3:0]        state,
   output logic [TURN_W-1:0] turns
);
   localparam logic [HP_W-1:0] CHP  = HP_W'(CATCH_HP);
   localparam logic [HP_W-1:0] ODDS = HP_W'(CATCH_ODDS);
   state_t     st;
   logic [1:0] move_q;
   logic       rise;
   logic       hit, ai_hit, catch_ok;
   go_edge u_go_edge (.clk(clk), .reset_n(reset_n), .go(go), .rise(rise));
   // Strobes are decided on the edge that enters their state, so rng/accu are sampled at the latch edge.
   assign hit      = rng < accu;
   assign ai_hit   = rng < ai_accu;
   assign catch_ok = (ai_hp <= CHP) && (rng < ODDS);
   assign state    = st;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         st              <= S_IDLE;
         move_q          <= 2'b00;
         turns           <= '0;
         load_ai_hp      <= 1'b0;
         apply_ai_damage <= 1'b0;
         apply_p_damage  <= 1'b0;
         p_heal          <= 1'b0;
         active_trainer  <= 1'b0;
         victory         <= 1'b0;
         loss            <= 1'b0;
         caught          <= 1'b0;
         missed          <= 1'b0;
      end else begin
         load_ai_hp      <= 1'b0;
         apply_ai_damage <= 1'b0;
         apply_p_damage  <= 1'b0;
         p_heal          <= 1'b0;
         missed          <= 1'b0;
         case (st)
            S_IDLE: begin
               st         <= S_LOAD;
               load_ai_hp <= 1'b1;
            end
            S_LOAD: st <= S_WAIT_GO;
            S_WAIT_GO:
               if (rise) begin
                  st              <= S_P_ACT;
                  move_q          <= move_op;
                  apply_ai_damage <= (move_op == MOVE_ATK) && hit;
                  p_heal          <= move_op == MOVE_HEAL;
                  missed          <= ((move_op == MOVE_ATK) && !hit) || ((move_op == MOVE_CATCH) && !catch_ok);
               end
            S_P_ACT:
               if (move_q == MOVE_RUN) begin
                  st   <= S_LOSE;
                  loss <= 1'b1;
               end else if (move_q == MOVE_CATCH && !missed) begin
                  st      <= S_WIN;
                  victory <= 1'b1;
                  caught  <= 1'b1;
               end else
                  st <= S_P_CHK;
            S_P_CHK:
               if (ai_dead) begin
                  st      <= S_WIN;
                  victory <= 1'b1;
               end else begin
                  st             <= S_AI_ACT;
                  turns          <= turns + TURN_W'(turns != '1);
                  active_trainer <= 1'b1;
                  apply_p_damage <= ai_hit;
                  missed         <= !ai_hit;
               end
            S_AI_ACT: st <= S_AI_CHK;
            S_AI_CHK: begin
               active_trainer <= 1'b0;
               st             <= p_dead ? S_LOSE : S_WAIT_GO;
               loss           <= p_dead;
            end
            S_WIN, S_LOSE:
               if (rise) begin
                  st      <= S_IDLE;
                  victory <= 1'b0;
                  loss    <= 1'b0;
                  caught  <= 1'b0;
                  turns   <= '0;
               end
            default: st <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_battle_turn_ctrl.sv
// tb_battle_turn_ctrl: per-turn timeline model of the sequencer, checked against the DUT every cycle.
module tb_battle_turn_ctrl;
   logic clk = 1'b0, reset_n = 1'b0, go = 1'b0;
   logic [1:0] move_op = 2'b00;
   logic [3:0] accu = 4'd0, ai_accu = 4'd0, rng = 4'd0, ai_hp = 4'd0;
   logic p_dead = 1'b0, ai_dead = 1'b0;
   logic load_ai_hp, apply_ai_damage, apply_p_damage, p_heal, active_trainer;
   logic victory, loss, caught, missed;
   logic [3:0] state;
   logic [7:0] turns;
   typedef struct packed {
      logic [3:0] st;
      logic load, aid, pd, heal, act, vic, los, cau, mis;
      logic [7:0] turns;
   } exp_t;
   exp_t e = '0;
   bit cmp_en = 1'b0, vic = 1'b0, los = 1'b0, cau = 1'b0, did_rst = 1'b0;
   int tcnt = 0, checks = 0, errors = 0;
   always #5 clk = ~clk;
   battle_turn_ctrl dut (
      .clk(clk), .reset_n(reset_n), .go(go), .move_op(move_op), .accu(accu), .ai_accu(ai_accu),
      .rng(rng), .ai_hp(ai_hp), .p_dead(p_dead), .ai_dead(ai_dead), .load_ai_hp(load_ai_hp),
      .apply_ai_damage(apply_ai_damage), .apply_p_damage(apply_p_damage), .p_heal(p_heal),
      .active_trainer(active_trainer), .victory(victory), .loss(loss), .caught(caught),
      .missed(missed), .state(state), .turns(turns)
   );
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
      end
   endtask
   always @(negedge clk)
      if (cmp_en) begin
         chk("state", state, e.st);
         chk("load_ai_hp", load_ai_hp, e.load);
         chk("apply_ai_damage", apply_ai_damage, e.aid);
         chk("apply_p_damage", apply_p_damage, e.pd);
         chk("p_heal", p_heal, e.heal);
         chk("active_trainer", active_trainer, e.act);
         chk("victory", victory, e.vic);
         chk("loss", loss, e.los);
         chk("caught", caught, e.cau);
         chk("missed", missed, e.mis);
         chk("turns", turns, e.turns);
      end
   function automatic exp_t mk(input logic [3:0] s);
      exp_t x = '0;
      x.st = s;
      x.vic = vic;
      x.los = los;
      x.cau = cau;
      x.turns = (tcnt > 255) ? 8'd255 : tcnt[7:0];
      return x;
   endfunction
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic release_rst();
      cyc(); reset_n = 1'b1; e = mk(4'd0);
      cyc(); e = mk(4'd1); e.load = 1'b1;
      cyc(); e = mk(4'd2);
   endtask
   // One player turn from WAIT_GO; every expected cycle is written out from the turn's rules.
   task automatic turn(input logic [1:0] mv, input logic [3:0] ac, r1, hp, aac, r2,
                       input bit ad, pd, hold, glitch, rst_ai);
      bit hit, ok, aih;
      hit = r1 < ac;
      ok = (hp <= 4'd3) && (r1 < 4'd8);
      aih = r2 < aac;
      cyc(); go = 1'b1; move_op = mv; accu = ac; rng = r1; ai_hp = hp; e = mk(4'd2);
      cyc(); e = mk(4'd2);
      cyc(); e = mk(4'd3);
      e.aid = (mv == 2'd0) && hit;
      e.mis = ((mv == 2'd0) && !hit) || ((mv == 2'd2) && !ok);
      e.heal = mv == 2'd1;
      if (!hold) go = 1'b0;
      move_op = 2'($urandom); accu = 4'($urandom);
      cyc();
      if (mv == 2'd3) begin
         los = 1'b1; e = mk(4'd8);
      end else if (mv == 2'd2 && ok) begin
         vic = 1'b1; cau = 1'b1; e = mk(4'd7);
      end else begin
         e = mk(4'd4); ai_dead = ad; rng = r2; ai_accu = aac;
         if (glitch && !hold && !ad) go = 1'b1;
         cyc(); ai_dead = 1'b0;
         if (glitch && !hold) go = 1'b0;
         if (ad) begin
            vic = 1'b1; e = mk(4'd7);
         end else begin
            tcnt++;
            e = mk(4'd5); e.act = 1'b1; e.pd = aih; e.mis = !aih;
            rng = 4'($urandom); ai_accu = 4'($urandom);
            if (rst_ai) begin
               reset_n = 1'b0; go = 1'b0; tcnt = 0; vic = 1'b0; los = 1'b0; cau = 1'b0;
               e = '0; did_rst = 1'b1;
            end else begin
               cyc(); e = mk(4'd6); e.act = 1'b1; p_dead = pd;
               cyc(); p_dead = 1'b0;
               if (pd) begin
                  los = 1'b1; e = mk(4'd8);
               end else
                  e = mk(4'd2);
            end
         end
      end
   endtask
   task automatic end_battle();
      logic [3:0] s;
      s = vic ? 4'd7 : 4'd8;
      cyc(); go = 1'b0; e = mk(s);
      cyc(); go = 1'b1; e = mk(s);
      cyc(); e = mk(s);
      cyc(); go = 1'b0; vic = 1'b0; los = 1'b0; cau = 1'b0; tcnt = 0; e = mk(4'd0);
      cyc(); e = mk(4'd1); e.load = 1'b1;
      cyc(); e = mk(4'd2);
   endtask
   // A held go must not start another turn; drop it only after a few idle WAIT_GO cycles.
   task automatic settle();
      if (go) begin
         repeat (3) begin
            cyc(); e = mk(4'd2);
         end
         cyc(); go = 1'b0; e = mk(4'd2);
      end
   endtask
   task automatic post();
      if (did_rst) begin
         did_rst = 1'b0;
         release_rst();
      end else if (vic || los)
         end_battle();
      else
         settle();
   endtask
   initial begin
      cmp_en = 1'b1;
      repeat (3) cyc();
      release_rst();
      @(negedge clk); chk("lit_state_after_reset", state, 4'd2);
      turn(2'd0, 4'd10, 4'd3, 4'd9, 4'd0, 4'd0, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit_win_victory", victory, 1);
      chk("lit_win_turns", turns, 0);
      chk("lit_win_no_p_damage", apply_p_damage, 0);
      post();
      turn(2'd0, 4'd10, 4'd3, 4'd9, 4'd5, 4'd2, 0, 0, 0, 0, 0); post();
      turn(2'd0, 4'd10, 4'd12, 4'd9, 4'd5, 4'd9, 0, 0, 0, 1, 0); post();
      turn(2'd0, 4'd0, 4'd0, 4'd9, 4'd15, 4'd15, 0, 0, 0, 0, 0); post();
      turn(2'd0, 4'd15, 4'd15, 4'd9, 4'd15, 4'd14, 0, 0, 0, 0, 0); post();
      turn(2'd0, 4'd15, 4'd14, 4'd9, 4'd0, 4'd0, 0, 0, 0, 0, 0); post();
      turn(2'd2, 4'd0, 4'd5, 4'd2, 4'd0, 4'd0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("lit_catch_caught", caught, 1);
      chk("lit_catch_victory", victory, 1);
      post();
      turn(2'd2, 4'd0, 4'd5, 4'd4, 4'd0, 4'd0, 0, 0, 0, 0, 0); post();
      turn(2'd1, 4'd0, 4'd0, 4'd9, 4'd15, 4'd0, 0, 1, 0, 0, 0);
      @(negedge clk); chk("lit_lose_loss", loss, 1);
      post();
      turn(2'd3, 4'd0, 4'd0, 4'd9, 4'd0, 4'd0, 0, 0, 0, 0, 0); post();
      turn(2'd0, 4'd10, 4'd3, 4'd9, 4'd15, 4'd0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk("lit_rst_state", state, 0);
      chk("lit_rst_strobe", apply_p_damage, 0);
      post();
      turn(2'd1, 4'd0, 4'd0, 4'd9, 4'd3, 4'd7, 0, 0, 1, 0, 0); post();
      repeat (260) begin
         turn(2'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
              4'($urandom), 0, 0, 0, 0, 0);
         post();
      end
      @(negedge clk); chk("lit_turns_saturated", turns, 255);
      repeat (150) begin
         turn(($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), 4'($urandom), 4'($urandom),
              4'($urandom_range(0, 6)), 4'($urandom), 4'($urandom), $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 29) == 0);
         post();
      end
      cyc();
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
